imm_gen: RTL and testbench

//   RV32I immediate generator for the ID stage. Extracts and sign/zero-extends the

---
 rtl/imm_pkg.sv | 15 +
 rtl/imm_decode.sv | 36 +++
 rtl/imm_gen.sv | 52 +++++
 tb/tb_imm_gen.sv | 107 ++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared immediate-format select encoding for the RV32I immediate generator.
// The control decoder imports this package so both sides agree on immsel values.
package imm_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] IMM_I    = 3'd0;
    localparam logic [2:0] IMM_S    = 3'd1;
    localparam logic [2:0] IMM_B    = 3'd2;
    localparam logic [2:0] IMM_U    = 3'd3;
    localparam logic [2:0] IMM_J    = 3'd4;
    localparam logic [2:0] IMM_CSR  = 3'd5;
    localparam logic [2:0] IMM_NONE = 3'd7;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction: slices and extends inst according to immsel.
// Build option: IMMGEN_CSR_EN enables the zero-extended CSR zimm format on select 5.
module imm_decode
    import imm_pkg::*;
(
    input  logic [XLEN-1:0] inst,
    input  logic [2:0]      immsel,
    output logic [XLEN-1:0] value,
    output logic            illegal
);

    logic sign;
    assign sign = inst[31];

    // Opcode bits never contribute to any immediate format.
    logic unused_opcode;
    assign unused_opcode = ^inst[6:0];

    always_comb begin
        // NOTE: defaults on every path keep this purely combinational (no latch).
        value   = '0;
        illegal = 1'b0;
        case (immsel)
            IMM_I:   value = {{20{sign}}, inst[31:20]};
            IMM_S:   value = {{20{sign}}, inst[31:25], inst[11:7]};
            IMM_B:   value = {{19{sign}}, sign, inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   value = {inst[31:12], 12'b0};
            IMM_J:   value = {{11{sign}}, sign, inst[19:12], inst[20], inst[30:21], 1'b0};
`ifdef IMMGEN_CSR_EN
            IMM_CSR: value = {27'b0, inst[19:15]};
`endif
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen.sv
// ID-stage immediate generator: decoded immediate registered with stall-hold and sync reset.
// Build option: IMMGEN_CSR_EN (passed through to imm_decode) enables the CSR zimm format.
module imm_gen
    import imm_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [XLEN-1:0] inst,
    input  logic [2:0]      immsel,
    output logic [XLEN-1:0] imm,
    output logic            imm_illegal
);

    logic [XLEN-1:0] dec_value;
    logic            dec_illegal;

    logic [XLEN-1:0] imm_d,     imm_q;
    logic            illegal_d, illegal_q;

    imm_decode u_decode (
        .inst    (inst),
        .immsel  (immsel),
        .value   (dec_value),
        .illegal (dec_illegal)
    );

    always_comb begin
        imm_d     = imm_q;
        illegal_d = illegal_q;
        if (en) begin
            imm_d     = dec_value;
            illegal_d = dec_illegal;
        end
    end

    // Reset is sampled on the clock edge and takes priority over en.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            imm_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            imm_q     <= imm_d;
            illegal_q <= illegal_d;
        end
    end

    assign imm         = imm_q;
    assign imm_illegal = illegal_q;

endmodule

// File: tb/tb_imm_gen.sv
// Directed self-checking bench for imm_gen; expected values are hand-derived from the field layouts.
// Honors IMMGEN_CSR_EN to pick the expected result for select 5.
module tb_imm_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] inst;
    logic [2:0]  immsel;
    logic [31:0] imm;
    logic        imm_illegal;

    int tests  = 0;
    int failed = 0;

    imm_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .inst        (inst),
        .immsel      (immsel),
        .imm         (imm),
        .imm_illegal (imm_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] exp_imm, input logic exp_ill);
        tests++;
        assert (imm === exp_imm) else begin
            failed++;
            $error("FAIL %s: imm=0x%08h expected 0x%08h", tag, imm, exp_imm);
        end
        tests++;
        assert (imm_illegal === exp_ill) else begin
            failed++;
            $error("FAIL %s: imm_illegal=%b expected %b", tag, imm_illegal, exp_ill);
        end
    endtask

    // Apply inputs, let one rising edge capture them, sample 1 time unit later.
    task automatic step(input logic [31:0] i, input logic [2:0] sel);
        inst   = i;
        immsel = sel;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b1;
        inst   = 32'hdead_beef;
        immsel = 3'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset", 32'h0000_0000, 1'b0);
        rst_n = 1'b1;

        // addi x2,x2,0x600 sliced in every format
        step(32'h6001_0113, 3'd0); check("addi_I", 32'h0000_0600, 1'b0);
        step(32'h6001_0113, 3'd1); check("addi_S", 32'h0000_0602, 1'b0);
        step(32'h6001_0113, 3'd2); check("addi_B", 32'h0000_0602, 1'b0);
        step(32'h6001_0113, 3'd3); check("addi_U", 32'h6001_0000, 1'b0);
        step(32'h6001_0113, 3'd4); check("addi_J", 32'h0001_0600, 1'b0);

        step(32'h00e1_2423, 3'd0); check("sw_I",  32'h0000_000e, 1'b0);
        step(32'h00e1_2423, 3'd1); check("sw_S",  32'h0000_0008, 1'b0);
        step(32'h0020_8863, 3'd2); check("beq_B", 32'h0000_0010, 1'b0);
        step(32'h0054_12b7, 3'd3); check("lui_U", 32'h0054_1000, 1'b0);
        step(32'h00c0_00ef, 3'd4); check("jal_J", 32'h0000_000c, 1'b0);

        step(32'hfff0_0093, 3'd0); check("neg1_I", 32'hffff_ffff, 1'b0);
        // negative S/B/J offsets: sign bits fill the top, B/J stay even
        step(32'hfe00_0fa3, 3'd1); check("negS",   32'hffff_ffff, 1'b0);
        step(32'hfe00_0ee3, 3'd2); check("negB",   32'hffff_fffc, 1'b0);
        step(32'hffdf_f06f, 3'd4); check("negJ",   32'hffff_fffc, 1'b0);

`ifdef IMMGEN_CSR_EN
        step(32'h51e0_d073, 3'd5); check("csr_zimm", 32'h0000_0001, 1'b0);
`else
        step(32'h51e0_d073, 3'd5); check("csr_off",  32'h0000_0000, 1'b1);
`endif
        step(32'h51e0_d073, 3'd0); check("csr_I",  32'h0000_051e, 1'b0);
        step(32'h0031_00b3, 3'd7); check("rtype",  32'h0000_0000, 1'b1);
        step(32'hffff_ffff, 3'd6); check("rsvd6",  32'h0000_0000, 1'b1);

        // stall: outputs hold while en is low
        step(32'h6001_0113, 3'd0); check("pre_hold", 32'h0000_0600, 1'b0);
        en = 1'b0;
        step(32'hfff0_0093, 3'd0); check("hold1",  32'h0000_0600, 1'b0);
        step(32'h0031_00b3, 3'd7); check("hold2",  32'h0000_0600, 1'b0);
        en = 1'b1;
        step(32'h0031_00b3, 3'd7); check("resume", 32'h0000_0000, 1'b1);

        // reset overrides en and clears the illegal flag
        step(32'hfff0_0093, 3'd0); check("pre_rst", 32'hffff_ffff, 1'b0);
        rst_n = 1'b0;
        step(32'h0031_00b3, 3'd7); check("rst_en", 32'h0000_0000, 1'b0);
        rst_n = 1'b1;
        step(32'h0054_12b7, 3'd3); check("post_rst", 32'h0054_1000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
